// File: rtl/adpll_seq_pkg.sv
// rtl/adpll_seq_pkg.sv - shared enums and default timing for the ADPLL sequencing controller
package adpll_seq_pkg;

  // Same encoding that adpll_ctr0 uses on its mode input
  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } adpll_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_LOCK,
    ST_ACTIVE,
    ST_FAIL
  } seq_state_e;

  localparam int DEF_FCWW         = 26;
  localparam int DEF_RST_CYC      = 4;
  localparam int DEF_LOCK_TIMEOUT = 1024;
  localparam int DEF_LOCK_STABLE  = 16;
  localparam int DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/adpll_lock_qual.sv
// rtl/adpll_lock_qual.sv - consecutive-cycle stable counter plus saturating timeout timer
module adpll_lock_qual #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic lock_in,
  output logic lock_ok,
  output logic timeout
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  logic [TW-1:0] timer;
  logic [SW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      timer      <= '0;
      stable_cnt <= '0;
    end else if (en) begin
      if (timer != TW'(LOCK_TIMEOUT))
        timer <= timer + 1'b1;
      if (!lock_in)
        stable_cnt <= '0;
      else if (stable_cnt != SW'(LOCK_STABLE))
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Both flags fire on the cycle whose edge makes the count reach its limit
  assign lock_ok = en && lock_in && (stable_cnt == SW'(LOCK_STABLE - 1));
  assign timeout = en && (timer >= TW'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/adpll_seq_ctr.sv
// rtl/adpll_seq_ctr.sv - ADPLL tune/lock sequencer; ADPLL_SEQ_LOCK_MON_EN adds the loss-of-lock monitor
module adpll_seq_ctr
  import adpll_seq_pkg::*;
#(
  parameter int FCWW         = DEF_FCWW,
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FCWW-1:0] req_fcw,
  input  logic [1:0]      req_mode,
  input  logic            stop,
  input  logic            channel_lock,
  input  logic            data_mod_in,
  output logic            adpll_rst,
  output logic            adpll_en,
  output logic [1:0]      adpll_mode,
  output logic [FCWW-1:0] adpll_fcw,
  output logic            data_mod_out,
  output logic            locked,
  output logic            fail,
`ifdef ADPLL_SEQ_LOCK_MON_EN
  output logic            lol,
`endif
  output logic [1:0]      retry_cnt
);

  localparam int RCW = $clog2(RST_CYC + 1);

  seq_state_e      state, state_nxt;
  logic [RCW-1:0]  rst_cnt;
  logic [FCWW-1:0] fcw_nxt;
  logic [1:0]      mode_nxt, retry_nxt;
  logic            accept, last_try, rst_done, q_lock_ok, q_timeout, lol_event;

  assign req_ready = (state == ST_IDLE || state == ST_ACTIVE || state == ST_FAIL) && !stop && !rst;
  assign accept    = req_valid && req_ready;
  assign last_try  = (retry_cnt == 2'(MAX_RETRY));
  assign rst_done  = (rst_cnt == RCW'(RST_CYC - 1));

  adpll_lock_qual #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE)) u_qual (
    .clk(clk), .rst(rst), .clr(state != ST_LOCK), .en(state == ST_LOCK),
    .lock_in(channel_lock), .lock_ok(q_lock_ok), .timeout(q_timeout)
  );

`ifdef ADPLL_SEQ_LOCK_MON_EN
  logic mon_en, mon_unused_timeout;
  assign mon_en = (state == ST_ACTIVE) && (adpll_mode == MODE_RX || adpll_mode == MODE_TX);

  // Same qualifier, watching for a run of missing lock instead of a run of lock
  adpll_lock_qual #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE)) u_mon (
    .clk(clk), .rst(rst), .clr(!mon_en), .en(mon_en),
    .lock_in(!channel_lock), .lock_ok(lol_event), .timeout(mon_unused_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst || stop || accept) lol <= 1'b0;
    else if (lol_event)        lol <= 1'b1;
  end
`else
  assign lol_event = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fcw_nxt   = adpll_fcw;
    mode_nxt  = adpll_mode;
    retry_nxt = retry_cnt;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (accept) begin
      retry_nxt = '0;
      if (req_mode == MODE_PD) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_RST;
        fcw_nxt   = req_fcw;
        mode_nxt  = req_mode;
      end
    end else begin
      case (state)
        ST_RST:
          if (rst_done) state_nxt = (adpll_mode == MODE_TEST) ? ST_ACTIVE : ST_LOCK;
        ST_LOCK:
          if (q_lock_ok) begin
            state_nxt = ST_ACTIVE;
          end else if (q_timeout) begin
            if (last_try) state_nxt = ST_FAIL;
            else begin
              state_nxt = ST_RST;
              retry_nxt = retry_cnt + 1'b1;
            end
          end
        ST_ACTIVE:
          if (lol_event) begin
            if (last_try) state_nxt = ST_FAIL;
            else begin
              state_nxt = ST_RST;
              retry_nxt = retry_cnt + 1'b1;
            end
          end
        default: ;
      endcase
    end
    if (state_nxt == ST_IDLE || state_nxt == ST_FAIL) mode_nxt = MODE_PD;
  end

  // Outputs are registered decodes of the next state so they change on the transition edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rst_cnt      <= '0;
      adpll_rst    <= 1'b0;
      adpll_en     <= 1'b0;
      adpll_mode   <= MODE_PD;
      adpll_fcw    <= '0;
      retry_cnt    <= '0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      data_mod_out <= 1'b0;
    end else begin
      state        <= state_nxt;
      rst_cnt      <= (state == ST_RST && state_nxt == ST_RST) ? rst_cnt + 1'b1 : '0;
      adpll_rst    <= (state_nxt == ST_RST);
      adpll_en     <= (state_nxt == ST_LOCK || state_nxt == ST_ACTIVE);
      adpll_mode   <= mode_nxt;
      adpll_fcw    <= fcw_nxt;
      retry_cnt    <= retry_nxt;
      locked       <= (state_nxt == ST_ACTIVE);
      fail         <= (state_nxt == ST_FAIL);
      data_mod_out <= (state == ST_ACTIVE) && (state_nxt == ST_ACTIVE) &&
                      (adpll_mode == MODE_TX) && data_mod_in;
    end
  end

endmodule

// File: doc/adpll_seq_ctr.md
Name: adpll_seq_ctr

Overview:
Sequencing controller for the adpll_ctr0 / dco / tdc_analog loop. It accepts channel requests (FCW plus mode) over a valid/ready handshake and drives the ADPLL reset, enable, mode and FCW. It qualifies channel_lock, retries locking on timeout and gates TX modulation data until lock is confirmed. It sits between the radio MAC/register file and adpll_ctr0.

Parameters:
FCWW, 26, FCW width (channel MHz * 16384)
RST_CYC, 4, cycles adpll_rst is held per (re)tune attempt
LOCK_TIMEOUT, 1024, cycles allowed in LOCK per attempt (32 us at 32 MHz)
LOCK_STABLE, 16, consecutive channel_lock cycles required to declare lock
MAX_RETRY, 3, retries after the first attempt before FAIL

Ports:
clk  in  1  system clock (32 MHz)
rst  in  1  synchronous active-high reset
req_valid  in  1  channel request valid
req_ready  out  1  controller can accept a request
req_fcw  in  FCWW  requested FCW
req_mode  in  2  requested mode: PD=0, TEST=1, RX=2, TX=3
stop  in  1  abort and power down the ADPLL
channel_lock  in  1  lock indication from adpll_ctr0
data_mod_in  in  1  TX modulation bit from MAC
adpll_rst  out  1  reset to adpll_ctr0
adpll_en  out  1  enable to adpll_ctr0
adpll_mode  out  2  mode to adpll_ctr0
adpll_fcw  out  FCWW  FCW to adpll_ctr0
data_mod_out  out  1  gated modulation bit to adpll_ctr0
locked  out  1  lock qualified, block is in ACTIVE
fail  out  1  all lock attempts exhausted
retry_cnt  out  2  attempts used in the current request

Behaviour:
- Reset values (registered outputs): adpll_rst=0, adpll_en=0, adpll_mode=PD, adpll_fcw=0, data_mod_out=0, locked=0, fail=0, retry_cnt=0. State is IDLE.
- req_ready is combinational: 1 in IDLE, ACTIVE and FAIL, and only when stop=0 and rst=0.
- A request is accepted when req_valid && req_ready. On acceptance, req_fcw and req_mode are latched into adpll_fcw/adpll_mode on the next edge and retry_cnt is cleared.
- Accepted req_mode=PD behaves as stop.
- IDLE: adpll_en=0, adpll_mode=PD. Accepted request -> RST.
- RST: adpll_rst=1 for exactly RST_CYC cycles. adpll_en=0 and adpll_mode holds the latched mode. The lock timer and stable counter are cleared. Exit: TEST -> ACTIVE; RX/TX -> LOCK.
- LOCK: adpll_en=1 and the timer increments each cycle. The stable counter increments while channel_lock=1 and clears to 0 on channel_lock=0.
  - Stable counter reaches LOCK_STABLE -> ACTIVE, with locked=1 on the same edge.
  - Else, timer reaches LOCK_TIMEOUT -> if retry_cnt==MAX_RETRY go to FAIL, otherwise increment retry_cnt and go to RST.
  - Lock qualification and timeout on the same cycle: lock wins.
- ACTIVE: locked=1, adpll_en=1.
  - data_mod_out <= data_mod_in when adpll_mode==TX, else 0 (one-cycle registered latency).
  - A new accepted request retunes: go to RST, locked=0 and data_mod_out=0 on the next edge.
- FAIL: fail=1, adpll_en=0, adpll_mode=PD.
  - Accepted request -> RST and clears fail.
  - stop -> IDLE and clears fail.
- stop has highest priority in every state. The next edge goes to IDLE with adpll_en=0, adpll_mode=PD, adpll_rst=0, locked=0, data_mod_out=0. adpll_fcw holds its value.
- stop and req_valid on the same cycle: stop wins and the request is not accepted (req_ready=0).
- The timer saturates at LOCK_TIMEOUT and never wraps. retry_cnt is sized for MAX_RETRY<=3.
- rst mid-operation returns the block to reset values on the next edge regardless of state.

Optional Feature:
ADPLL_SEQ_LOCK_MON_EN
- Defined: in ACTIVE (RX/TX only), channel_lock=0 for LOCK_STABLE consecutive cycles is a loss-of-lock event.
  - Loss of lock sets a sticky output lol (1 bit, cleared on accepted request or stop).
  - Loss of lock forces data_mod_out=0 and re-enters RST without a new request.
  - These relocks consume the retry budget.
- Undefined: channel_lock is ignored in ACTIVE, and lol is not present.

Decomposition:
- Package adpll_seq_pkg holds:
  - the mode enum (PD, TEST, RX, TX), reusing the 2'd0..2'd3 encoding of adpll_ctr0;
  - the state enum (IDLE, RST, LOCK, ACTIVE, FAIL);
  - default timing constants.
- One sub-module, adpll_lock_qual: stable counter plus timeout timer. It has clear/enable inputs and lock_ok/timeout outputs, and is reused by the loss-of-lock monitor.

Test Plan:
- Reset then request RX, FCW=2480*16384: adpll_rst high 4 cycles, then en=1. channel_lock forced high at cycle 10 -> locked=1 exactly 16 cycles later; data_mod_out stays 0.
- TX request with lock: data_mod_in toggled -> data_mod_out follows with 1-cycle latency only while locked=1.
- channel_lock held 0 -> 4 attempts of 4+1024 cycles with retry_cnt 0..3, then fail=1, adpll_en=0, adpll_mode=PD. A new request clears fail.
- channel_lock pulses high 15 cycles, low 1, repeatedly -> never locks, timeout path taken. Lock completing on the timeout cycle -> locked wins.
- stop and req_valid in the same cycle during LOCK -> IDLE next cycle, req not accepted, adpll_fcw unchanged. A retune request in ACTIVE -> locked drops next edge and adpll_rst pulses.
- With ADPLL_SEQ_LOCK_MON_EN: channel_lock drops for 16 cycles in ACTIVE -> lol=1, data_mod_out=0, RST re-entered. Drop of 15 cycles -> no event.
